// File: rtl/scan_counter.sv
`default_nettype none
// ============================================================================
//  Module   : scan_counter
//  Brief    : Raster scan counter for the VGA timing path: pixel enable,
//             horizontal/vertical counts, vertical blank/sync, line/frame strobes.
//  Revision : 1.0
// ============================================================================
module scan_counter #(
  parameter int   PIX_DIV      = 4,
  parameter int   H_LAST       = 264,
  parameter int   V_VISIBLE    = 600,
  parameter int   V_SYNC_START = 601,
  parameter int   V_SYNC_END   = 605,
  parameter int   V_LAST       = 627,
  parameter logic V_SYNC_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hRst,
  output logic       pixEn,
  output logic [8:0] hCount,
  output logic [9:0] vCount,
  output logic       vVisible,
  output logic       vSync,
  output logic       lineStart,
  output logic       frameStart
);

  localparam int               DIV_W     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(PIX_DIV - 1);
  localparam logic [8:0]       H_MAX     = 9'(H_LAST);
  localparam logic [9:0]       V_MAX     = 10'(V_LAST);
  localparam logic [9:0]       V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0]       VS_START  = 10'(V_SYNC_START);
  localparam logic [9:0]       VS_END    = 10'(V_SYNC_END);

  logic [DIV_W-1:0] div_cnt;
  logic             div_last;
  logic             line_wrap;
  logic             frame_wrap;
  logic [9:0]       v_next;
  logic             v_next_sync;

  // The >= guards also pull an out-of-range count back to zero.
  always_comb begin
    div_last    = (div_cnt == DIV_MAX);
    line_wrap   = hRst | (hCount >= H_MAX);
    frame_wrap  = (vCount >= V_MAX);
    v_next      = vCount;
    if (pixEn && line_wrap) begin
      v_next = frame_wrap ? 10'd0 : vCount + 10'd1;
    end
    v_next_sync = (v_next >= VS_START) && (v_next < VS_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      pixEn      <= 1'b0;
      hCount     <= '0;
      vCount     <= '0;
      vVisible   <= 1'b1;
      vSync      <= ~V_SYNC_POL;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      div_cnt    <= div_last ? '0 : div_cnt + 1'b1;
      pixEn      <= div_last;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
      if (pixEn) begin
        if (line_wrap) begin
          hCount     <= '0;
          vCount     <= v_next;
          lineStart  <= 1'b1;
          frameStart <= frame_wrap;
        end else begin
          hCount <= hCount + 9'd1;
        end
      end
      // Decoded from the next count so blank/sync move in step with vCount.
      vVisible <= (v_next < V_VIS_END);
      vSync    <= v_next_sync ? V_SYNC_POL : ~V_SYNC_POL;
    end
  end

endmodule
`default_nettype wire
